mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/arb_pkg.sv | 24 ++
 rtl/arb_counter.sv | 39 +++
 rtl/mem_bus_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types for the memory bus arbiter: FSM states, bus owner encoding and tag field layout.
package arb_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StResp,
        StDone
    } arb_state_e;

    typedef enum logic {
        OwnFetch = 1'b0,
        OwnData  = 1'b1
    } arb_owner_e;

    // Tag layout is {we, zeros, owner}.
    localparam int unsigned TagOwnerBit = 0;

    function automatic int unsigned tag_we_bit(input int unsigned tag_width);
        return tag_width - 1;
    endfunction

endpackage

// File: rtl/arb_counter.sv
// Saturating up-counter with synchronous clear, used for the response beat count and the
// fetch starvation count.
module arb_counter #(
    parameter int unsigned Width = 3,
    parameter int unsigned Max   = 7
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             sat_o
);

    localparam logic [Width-1:0] MaxVal = Width'(Max);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == MaxVal);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch, data) arbiter onto a single tagged request/response memory bus.
// Optional fetch starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_bus_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned BURST_BEATS    = 8,
    parameter int unsigned STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      if_req,
    input  logic [BUS_DATA_WIDTH-1:0] if_addr,
    output logic                      if_gnt,
    output logic [BUS_DATA_WIDTH-1:0] if_rdata,
    output logic                      if_rvalid,
    output logic                      if_done,
    input  logic                      dm_req,
    input  logic                      dm_we,
    input  logic [BUS_DATA_WIDTH-1:0] dm_addr,
    input  logic [BUS_DATA_WIDTH-1:0] dm_wdata,
    output logic                      dm_gnt,
    output logic [BUS_DATA_WIDTH-1:0] dm_rdata,
    output logic                      dm_rvalid,
    output logic                      dm_done,
    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic                      bus_respack
);

    localparam int unsigned TagWeBit = tag_we_bit(BUS_TAG_WIDTH);
    localparam int unsigned BeatW    = $clog2(BURST_BEATS + 1);
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_BEATS - 1);

    arb_state_e                state_q, state_d;
    arb_owner_e                owner_q, owner_d;
    logic                      we_q, we_d;
    logic [BUS_DATA_WIDTH-1:0] addr_q, addr_d;
    logic [BUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BUS_TAG_WIDTH-1:0]  tag;
    logic [BeatW-1:0]          beat_cnt;
    logic                      beat_inc, beat_clr, beat_sat;
    logic                      force_if, pick_dm;

    arb_counter #(
        .Width (BeatW),
        .Max   (BURST_BEATS)
    ) u_beat_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (beat_clr),
        .inc_i  (beat_inc),
        .cnt_o  (beat_cnt),
        .sat_o  (beat_sat)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

    logic [StarveW-1:0] starve_cnt;
    logic               starve_inc, starve_clr;

    arb_counter #(
        .Width (StarveW),
        .Max   (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .clr_i  (starve_clr),
        .inc_i  (starve_inc),
        .cnt_o  (starve_cnt),
        .sat_o  (force_if)
    );
`else
    assign force_if = 1'b0;
`endif

    // Stray beats are always drained; reset gating keeps the ack low while reset is held.
    assign bus_respack = reset_n & bus_respcyc;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        if_rdata   = '0;
        dm_rdata   = '0;
        if_rvalid  = 1'b0;
        dm_rvalid  = 1'b0;
        if_done    = 1'b0;
        dm_done    = 1'b0;
        bus_reqcyc = 1'b0;
        bus_req    = '0;
        beat_inc   = 1'b0;
        beat_clr   = 1'b0;
        pick_dm    = dm_req && !(force_if && if_req);
`ifdef ARB_STARVE_GUARD_EN
        starve_inc = 1'b0;
        starve_clr = 1'b0;
`endif
        tag              = '0;
        tag[TagWeBit]    = we_q;
        tag[TagOwnerBit] = owner_q;
        bus_reqtag       = '0;

        unique case (state_q)
            StIdle: begin
                // The IDLE state is also the reset state, so grants are masked by reset_n.
                if (reset_n && (dm_req || if_req)) begin
                    state_d = StAddr;
                    if (pick_dm) begin
                        owner_d = OwnData;
                        we_d    = dm_we;
                        addr_d  = dm_addr;
                        wdata_d = dm_wdata;
                        dm_gnt  = 1'b1;
                    end else begin
                        owner_d = OwnFetch;
                        we_d    = 1'b0;
                        addr_d  = if_addr;
                        wdata_d = '0;
                        if_gnt  = 1'b1;
                    end
`ifdef ARB_STARVE_GUARD_EN
                    starve_inc = pick_dm && if_req;
                    starve_clr = !pick_dm;
`endif
                end
            end
            StAddr: begin
                bus_reqcyc = 1'b1;
                bus_req    = addr_q;
                bus_reqtag = tag;
                if (bus_reqack) begin
                    state_d = we_q ? StWdata : StResp;
                end
            end
            StWdata: begin
                bus_reqcyc = 1'b1;
                bus_req    = wdata_q;
                bus_reqtag = tag;
                if (bus_reqack) begin
                    state_d = StDone;
                end
            end
            StResp: begin
                if (bus_respcyc) begin
                    if (owner_q == OwnData) begin
                        dm_rvalid = 1'b1;
                        dm_rdata  = bus_resp;
                    end else begin
                        if_rvalid = 1'b1;
                        if_rdata  = bus_resp;
                    end
                    beat_inc = 1'b1;
                    if (beat_cnt == LastBeat || beat_sat) begin
                        beat_clr = 1'b1;
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if_done = (owner_q == OwnFetch);
                dm_done = (owner_q == OwnData);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            owner_q <= OwnFetch;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
